// File: rtl/scan_select_gen.sv
// Round-robin select/enable generator for a 2-to-4 enable decoder.
// Each enabled index gets SCAN_DIV cycles of sel_en, then BLANK_CYC cycles of blanking.
module scan_select_gen #(
  parameter int DIV_W     = 16,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] digit_mask,
  output logic [1:0] sel,
  output logic       sel_en,
  output logic       frame_tick,
  output logic       busy
);

  // state   | meaning
  // S_IDLE  | stopped, sel_en low, sel held
  // S_ON    | slot active, sel_en high for SCAN_DIV cycles
  // S_BLANK | gap between slots, sel_en low for BLANK_CYC cycles
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ON    = 2'd1,
    S_BLANK = 2'd2
  } state_t;

  localparam bit               HAS_BLANK  = (BLANK_CYC > 0);
  localparam logic [DIV_W-1:0] SCAN_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_LAST = HAS_BLANK ? DIV_W'(BLANK_CYC - 1) : '0;

  state_t             r_state;
  logic [DIV_W-1:0]   r_cnt;
  logic [1:0]         r_sel;
  logic               r_sel_en;
  logic               r_frame_tick;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [DIV_W-1:0]   w_cnt_nxt;
  logic [1:0]         w_sel_nxt;
  logic               w_tick_nxt;
  logic               w_advance;
  logic [1:0]         w_first_idx;
  logic [1:0]         w_next_idx;

  function automatic logic [1:0] f_lowest(input logic [3:0] mask);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) idx = 2'(k);
    end
    return idx;
  endfunction

  // Search cur+1, cur+2, cur+3, then cur itself; the first hit wins.
  function automatic logic [1:0] f_next(input logic [3:0] mask, input logic [1:0] cur);
    logic [1:0] idx;
    logic [1:0] cand;
    logic       found;
    idx   = cur;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = cur + 2'(k);
      if (!found && mask[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  assign w_first_idx = f_lowest(digit_mask);
  assign w_next_idx  = f_next(digit_mask, r_sel);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    w_tick_nxt  = 1'b0;
    w_advance   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (run && (digit_mask != 4'd0)) begin
          w_state_nxt = S_ON;
          w_sel_nxt   = w_first_idx;
          w_cnt_nxt   = '0;
        end
      end
      S_ON: begin
        if (!run) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == SCAN_LAST) begin
          if (HAS_BLANK) begin
            w_state_nxt = S_BLANK;
            w_cnt_nxt   = '0;
          end else begin
            w_advance = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
      S_BLANK: begin
        if (!run) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == BLANK_LAST) begin
          w_advance = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + DIV_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    // Mask is only consulted here, so mid-slot changes never cut a slot or gap short.
    if (w_advance) begin
      w_cnt_nxt = '0;
      if (digit_mask == 4'd0) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt = S_ON;
        w_sel_nxt   = w_next_idx;
        w_tick_nxt  = (w_next_idx <= r_sel);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_sel        <= 2'd0;
      r_sel_en     <= 1'b0;
      r_frame_tick <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_sel        <= w_sel_nxt;
      r_sel_en     <= (w_state_nxt == S_ON);
      r_frame_tick <= w_tick_nxt;
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign sel        = r_sel;
  assign sel_en     = r_sel_en;
  assign frame_tick = r_frame_tick;
  assign busy       = r_busy;

endmodule

// File: tb/tb_scan_select_gen.sv
// Scoreboard bench for scan_select_gen: two instances (BLANK_CYC=1 and 0)
// share stimulus and are checked against a slot-age reference model.
module tb_scan_select_gen;

  localparam int SCAN_DIV = 3;
  localparam int PER0     = 4;   // SCAN_DIV + 1
  localparam int PER1     = 3;   // SCAN_DIV + 0

  typedef struct packed {
    logic [1:0] sel;
    logic       en;
    logic       tick;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [3:0] mask;

  logic [1:0] sel0, sel1;
  logic       en0, en1, tick0, tick1, busy0, busy1;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;

  // model state per instance: active flag, current index, cycles since slot start
  bit m_act[2];
  int m_cur[2];
  int m_age[2];

  scan_select_gen #(.DIV_W(16), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .run(run), .digit_mask(mask),
    .sel(sel0), .sel_en(en0), .frame_tick(tick0), .busy(busy0)
  );

  scan_select_gen #(.DIV_W(16), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .run(run), .digit_mask(mask),
    .sel(sel1), .sel_en(en1), .frame_tick(tick1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input int i, input int per, input logic rb, input logic ru,
                            input logic [3:0] m, output exp_t e);
    bit tick;
    int nxt;
    tick = 1'b0;
    if (!rb) begin
      m_act[i] = 1'b0; m_cur[i] = 0; m_age[i] = 0;
    end else if (!m_act[i]) begin
      if (ru && m != 4'd0) begin
        m_act[i] = 1'b1; m_age[i] = 0;
        m_cur[i] = 0;
        while (!m[m_cur[i]]) m_cur[i]++;
      end
    end else if (!ru) begin
      m_act[i] = 1'b0; m_age[i] = 0;
    end else if (m_age[i] == per - 1) begin
      m_age[i] = 0;
      if (m == 4'd0) begin
        m_act[i] = 1'b0;
      end else begin
        nxt = m_cur[i];
        for (int k = 4; k >= 1; k--)
          if (m[(m_cur[i] + k) % 4]) nxt = (m_cur[i] + k) % 4;
        tick = (nxt <= m_cur[i]);
        m_cur[i] = nxt;
      end
    end else begin
      m_age[i]++;
    end
    e.sel  = 2'(m_cur[i]);
    e.en   = m_act[i] && (m_age[i] < SCAN_DIV);
    e.tick = tick;
    e.busy = m_act[i];
  endtask

  task automatic drive(input logic rb, input logic ru, input logic [3:0] m);
    exp_t e;
    @(negedge clk);
    rst_n = rb; run = ru; mask = m;
    model_step(0, PER0, rb, ru, m, e); q0.push_back(e);
    model_step(1, PER1, rb, ru, m, e); q1.push_back(e);
  endtask

  task automatic hold(input int n, input logic rb, input logic ru, input logic [3:0] m);
    for (int c = 0; c < n; c++) drive(rb, ru, m);
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        n_cmp++;
        if ({sel0, en0, tick0, busy0} !== e) begin
          n_bad++;
          $display("FAIL blank1 t=%0t got sel=%0d en=%b tick=%b busy=%b want sel=%0d en=%b tick=%b busy=%b",
                   $time, sel0, en0, tick0, busy0, e.sel, e.en, e.tick, e.busy);
        end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        n_cmp++;
        if ({sel1, en1, tick1, busy1} !== e) begin
          n_bad++;
          $display("FAIL blank0 t=%0t got sel=%0d en=%b tick=%b busy=%b want sel=%0d en=%b tick=%b busy=%b",
                   $time, sel1, en1, tick1, busy1, e.sel, e.en, e.tick, e.busy);
        end
      end
    end
  end

  initial begin
    logic [3:0] rm;
    logic       rr, rb;
    rst_n = 1'b0; run = 1'b0; mask = 4'd0;
    for (int i = 0; i < 2; i++) begin m_act[i] = 0; m_cur[i] = 0; m_age[i] = 0; end

    hold(3, 1'b0, 1'b0, 4'b0000);
    // full scan, then reset mid-slot and restart
    hold(36, 1'b1, 1'b1, 4'b1111);
    hold(10, 1'b1, 1'b1, 4'b1111);
    hold(2,  1'b0, 1'b1, 4'b1111);
    hold(20, 1'b1, 1'b1, 4'b1111);
    // sparse and single-digit masks
    hold(30, 1'b1, 1'b1, 4'b1010);
    hold(20, 1'b1, 1'b1, 4'b0001);
    // run dropped mid-slot, then resumed
    hold(3,  1'b0, 1'b0, 4'b1111);
    hold(10, 1'b1, 1'b1, 4'b1111);
    hold(3,  1'b1, 1'b0, 4'b1111);
    hold(12, 1'b1, 1'b1, 4'b1111);
    // mask cleared mid-slot -> idle after slot and gap
    hold(6,  1'b1, 1'b1, 4'b0011);
    hold(10, 1'b1, 1'b1, 4'b0000);
    hold(20, 1'b1, 1'b1, 4'b0011);

    rm = 4'($urandom_range(0, 15));
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 11) == 0) rm = 4'($urandom_range(0, 15));
      rr = ($urandom_range(0, 29) != 0);
      rb = ($urandom_range(0, 149) != 0);
      drive(rb, rr, rm);
    end

    repeat (3) @(posedge clk);
    #2;
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_bad++;
      $display("FAIL drain got q0=%0d q1=%0d pending want 0", q0.size(), q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
